// File: rtl/ula_seq.sv
// ula_seq: sequential ALU stage.
// Operand A comes from the temp register (saidaUla). Operand B is captured from
// the shared Data bus when Start is accepted. The result is driven back onto Data
// on request.
// ADD/SUB/AND/OR/XOR/NOT take one EXEC cycle. SHL shifts one bit per cycle.
// MUL is a shift-add multiply.
// Build option: define ULA_SEQ_MUL_EN to include the iterative multiplier.
// Without it, Op 111 finishes in one cycle with result 0 and V set (unsupported).
module ula_seq #(
  parameter int Tamanho_Da_Palavra = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [Tamanho_Da_Palavra-1:0] saidaUla,
  inout  logic [Tamanho_Da_Palavra-1:0] Data,
  input  logic [2:0]                    Op,
  input  logic                          Start,
  input  logic                          Drive,
  output logic                          Busy,
  output logic                          Done,
  output logic [3:0]                    Flags
);

  localparam int W  = Tamanho_Da_Palavra;
  localparam int CW = ($clog2(W + 1) > 4) ? $clog2(W + 1) : 4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, result_reg;
  logic [2:0]      op_reg;
  logic [CW-1:0]   count_reg, count_init;
  logic [3:0]      flags_reg;
  logic            valid_reg;

  // Per-step and final combinational values.
  logic [W:0]      sum_ext, dif_ext;
  logic [W-1:0]    shl_a, fin_res;
  logic            shl_active, fin_c, fin_v;
  logic            last_step, drive_en;

`ifdef ULA_SEQ_MUL_EN
  logic [2*W-1:0]  prod_reg, mcand_reg, prod_step;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic. EXEC ends when the step counter reaches zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = EXEC;
      EXEC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign last_step = (count_reg == CW'(1));
  assign Busy      = (state_reg == EXEC);
  assign Done      = (state_reg == DONE);
  assign Flags     = flags_reg;

  // Number of EXEC cycles for the requested op.
  always_comb begin
    count_init = CW'(1);
    if (Op == 3'b110) begin
      if (Data[3:0] != 4'd0) count_init = CW'(Data[3:0]);
    end
`ifdef ULA_SEQ_MUL_EN
    else if (Op == 3'b111) begin
      count_init = CW'(W);
    end
`endif
  end

  // Datapath for one EXEC step, and the result/flags produced by the last step.
  always_comb begin
    sum_ext    = {1'b0, a_reg} + {1'b0, b_reg};
    dif_ext    = {1'b0, a_reg} + {1'b0, ~b_reg} + (W+1)'(1);
    shl_active = (b_reg[3:0] != 4'd0);
    shl_a      = {a_reg[W-2:0], 1'b0};
    fin_res    = '0;
    fin_c      = 1'b0;
    fin_v      = 1'b0;
`ifdef ULA_SEQ_MUL_EN
    prod_step  = prod_reg + (b_reg[0] ? mcand_reg : '0);
`endif
    case (op_reg)
      3'b000: begin
        fin_res = sum_ext[W-1:0];
        fin_c   = sum_ext[W];
        fin_v   = (a_reg[W-1] == b_reg[W-1]) && (sum_ext[W-1] != a_reg[W-1]);
      end
      3'b001: begin
        fin_res = dif_ext[W-1:0];
        fin_c   = dif_ext[W];
        fin_v   = (a_reg[W-1] != b_reg[W-1]) && (dif_ext[W-1] != a_reg[W-1]);
      end
      3'b010: fin_res = a_reg & b_reg;
      3'b011: fin_res = a_reg | b_reg;
      3'b100: fin_res = a_reg ^ b_reg;
      3'b101: fin_res = ~a_reg;
      3'b110: begin
        if (shl_active) begin
          fin_res = shl_a;
          fin_c   = a_reg[W-1];
        end else begin
          fin_res = a_reg;
        end
      end
      default: begin
`ifdef ULA_SEQ_MUL_EN
        fin_res = prod_step[W-1:0];
        fin_c   = |prod_step[2*W-1:W];
`else
        fin_v   = 1'b1;
`endif
      end
    endcase
  end

  // Operand capture, iteration registers and result/flags update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      valid_reg  <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
      prod_reg   <= '0;
      mcand_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            a_reg     <= saidaUla;
            b_reg     <= Data;
            op_reg    <= Op;
            count_reg <= count_init;
            valid_reg <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
            prod_reg  <= '0;
            mcand_reg <= {{W{1'b0}}, saidaUla};
`endif
          end
        end
        EXEC: begin
          count_reg <= count_reg - CW'(1);
          if (op_reg == 3'b110 && shl_active) a_reg <= shl_a;
`ifdef ULA_SEQ_MUL_EN
          if (op_reg == 3'b111) begin
            prod_reg  <= prod_step;
            mcand_reg <= {mcand_reg[2*W-2:0], 1'b0};
            b_reg     <= {1'b0, b_reg[W-1:1]};
          end
`endif
          if (last_step) begin
            result_reg <= fin_res;
            flags_reg  <= {(fin_res == '0), fin_res[W-1], fin_c, fin_v};
            valid_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result goes on the bus only when idle, valid, requested, and nobody is starting.
  assign drive_en = Drive && valid_reg && (state_reg == IDLE) && !Start && !Reset;
  assign Data     = drive_en ? result_reg : {W{1'bz}};

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq: directed vectors with a scoreboard.
// The stimulus pushes the expected response; the monitor pops it on each Done.
module tb_ula_seq;
  localparam int W = 16;

  logic          clk;
  logic          Reset, Start, Drive, tb_drv;
  logic [2:0]    Op;
  logic [W-1:0]  saidaUla, tb_data;
  wire  [W-1:0]  Data;
  logic          Busy, Done;
  logic [3:0]    Flags;

  assign Data = tb_drv ? tb_data : {W{1'bz}};

  ula_seq #(.Tamanho_Da_Palavra(W)) dut (
    .Clock(clk), .Reset(Reset), .saidaUla(saidaUla), .Data(Data), .Op(Op),
    .Start(Start), .Drive(Drive), .Busy(Busy), .Done(Done), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic [7:0]   busy;
  } exp_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic [7:0]   busy;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: on every Done, pop the expected response and compare flags, Busy
  // run length and, one cycle later, the result driven onto the bus.
  initial begin : monitor
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (Done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'b0, Done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("flags", {28'b0, Flags}, {28'b0, e.flags});
          chk("busy_len", busy_run, {24'b0, e.busy});
          chk("busy_in_done", {31'b0, Busy}, 32'd0);
          @(negedge clk);
          chk("done_width", {31'b0, Done}, 32'd0);
          chk("result_bus", {16'b0, Data}, {16'b0, e.res});
          $display("op done: result=%h flags=%b busy=%0d", Data, Flags, busy_run);
          done_seen++;
        end
        busy_run = 0;
      end else if (Busy === 1'b1) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    Start = 1'b1; Op = op; saidaUla = a; tb_data = b; tb_drv = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_seen == prev && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (done_seen == prev) begin
      chk("done_timeout", done_seen, prev + 1);
      sb.delete();
    end
  endtask

  task automatic expect_op(input vec_t v);
    int prev;
    prev = done_seen;
    sb.push_back(exp_t'{v.res, v.flags, v.busy});
    issue(v.op, v.a, v.b);
    wait_done(prev);
  endtask

  initial begin : stim
    int prev;
    Reset = 1'b1; Start = 1'b0; Drive = 1'b1; Op = 3'b000;
    saidaUla = '0; tb_data = 16'h5A5A; tb_drv = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_flags", {28'b0, Flags}, 32'd0);
    chk("reset_bus", {16'b0, Data}, 32'h5A5A);
    @(posedge clk); #1;
    Reset = 1'b0; tb_drv = 1'b0;

    // Directed vectors: op, A, B, result, {Z,N,C,V}, Busy cycles.
    vecs.push_back(vec_t'{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 8'd1});
    vecs.push_back(vec_t'{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 8'd1});
    vecs.push_back(vec_t'{3'b110, 16'h8001, 16'h0004, 16'h0010, 4'b0000, 8'd4});
    vecs.push_back(vec_t'{3'b110, 16'h8001, 16'h0000, 16'h8001, 4'b0100, 8'd1});
    vecs.push_back(vec_t'{3'b110, 16'h8001, 16'h0011, 16'h0002, 4'b0010, 8'd1});
    vecs.push_back(vec_t'{3'b110, 16'h4000, 16'h0002, 16'h0000, 4'b1010, 8'd2});
    vecs.push_back(vec_t'{3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 8'd1});
    vecs.push_back(vec_t'{3'b011, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 8'd1});
    vecs.push_back(vec_t'{3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 8'd1});
    vecs.push_back(vec_t'{3'b101, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 8'd1});
    vecs.push_back(vec_t'{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 8'd1});
    vecs.push_back(vec_t'{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 8'd1});
    vecs.push_back(vec_t'{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 8'd1});
`ifdef ULA_SEQ_MUL_EN
    vecs.push_back(vec_t'{3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 8'd16});
    vecs.push_back(vec_t'{3'b111, 16'h0003, 16'hFFFF, 16'hFFFD, 4'b0110, 8'd16});
`else
    vecs.push_back(vec_t'{3'b111, 16'h0003, 16'h0005, 16'h0000, 4'b1001, 8'd1});
`endif
    foreach (vecs[i]) expect_op(vecs[i]);

    // Bus handshake after an ADD with result 0x8000.
    expect_op(vec_t'{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 8'd1});
    @(posedge clk); #1;
    Drive = 1'b0; tb_drv = 1'b1; tb_data = 16'h1234;
    @(negedge clk);
    chk("release_drive0", {16'b0, Data}, 32'h1234);
    @(posedge clk); #1;
    Drive = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
    chk("drive_result", {16'b0, Data}, 32'h8000);

    // Start releases the bus even with a valid result and Drive=1; B is the bus value.
    prev = done_seen;
    sb.push_back(exp_t'{16'h92CB, 4'b0100, 8'd1});
    @(posedge clk); #1;
    Start = 1'b1; Op = 3'b100; saidaUla = 16'h9234; tb_data = 16'h00FF; tb_drv = 1'b1;
    @(negedge clk);
    chk("start_release", {16'b0, Data}, 32'h00FF);
    @(posedge clk); #1;
    Start = 1'b0; tb_drv = 1'b0;
    wait_done(prev);

    // Reset releases the bus combinationally, then clears flags.
    @(posedge clk); #1;
    Reset = 1'b1; tb_drv = 1'b1; tb_data = 16'h4000;
    @(negedge clk);
    chk("reset_release", {16'b0, Data}, 32'h4000);
    @(posedge clk); #1;
    Reset = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    chk("flags_after_reset", {28'b0, Flags}, 32'd0);

    // Start while busy is ignored: a single Done with the SHL result.
    prev = done_seen;
    sb.push_back(exp_t'{16'h0010, 4'b0000, 8'd4});
    issue(3'b110, 16'h8001, 16'h0004);
    @(posedge clk); #1;
    Start = 1'b1; Op = 3'b000; saidaUla = 16'hFFFF; tb_data = 16'hFFFF; tb_drv = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; tb_drv = 1'b0;
    wait_done(prev);
    repeat (8) @(posedge clk);

    // Reset at EXEC cycle 8 of a long op: abort, no Done, flags cleared.
    expect_op(vec_t'{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 8'd1});
`ifdef ULA_SEQ_MUL_EN
    issue(3'b111, 16'h0003, 16'hFFFF);
`else
    issue(3'b110, 16'hFFFF, 16'h000F);
`endif
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("busy_cycle8", {31'b0, Busy}, 32'd1);
    Reset = 1'b1; tb_drv = 1'b1; tb_data = 16'h0F0F;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_flags", {28'b0, Flags}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    chk("abort_bus", {16'b0, Data}, 32'h0F0F);
    tb_drv = 1'b0;
    repeat (25) @(posedge clk);

    // Recovery after the abort.
    expect_op(vec_t'{3'b000, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 8'd1});

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
